// File: rtl/orion_pkg.sv
// Shared constants and helpers for the orion click-based handshake blocks.
// The ORION_DLY_* values are picoseconds and are used only when ORION_FORK_SIM_DELAY_EN is defined.
package orion_pkg;

  localparam int ORION_DLY_GATE  = 10;
  localparam int ORION_DLY_CLICK = 15;
  localparam int ORION_DLY_REG   = 10;

  localparam int ORION_MAX_OUT = 64;

  // Returns a vector whose low n bits are set; callers cast it to their own width.
  function automatic logic [ORION_MAX_OUT-1:0] orion_all_ones(input int n);
    logic [ORION_MAX_OUT-1:0] v;
    v = '0;
    for (int k = 0; k < ORION_MAX_OUT; k++) begin
      if (k < n) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/orion_fork_slice.sv
// One fork output: its request phase, its data register, and its ready term toward the click.
// When not selected, the slice reports ready and holds its state, so a pending token here never stalls the fork.
module orion_fork_slice
  import orion_pkg::*;
#(
  parameter int               WIDTH  = 1,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter logic             P_INIT = 1'b1
) (
  input  logic             reset,
  input  logic             click,
  input  logic             sel,
  input  logic             out_ack,
  input  logic [WIDTH-1:0] data_in,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  output logic             ready
);

  logic             phase_q, phase_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             bubble;

`ifdef ORION_FORK_SIM_DELAY_EN
  assign #(ORION_DLY_GATE * 1ps) bubble = ~(phase_q ^ out_ack);
`else
  assign bubble = ~(phase_q ^ out_ack);
`endif

  assign ready = bubble | ~sel;

  always_comb begin
    phase_d = phase_q ^ sel;
    data_d  = sel ? data_in : data_q;
  end

  always_ff @(posedge click or posedge reset) begin
    if (reset) begin
      phase_q <= P_INIT;
      data_q  <= INIT;
    end else begin
`ifdef ORION_FORK_SIM_DELAY_EN
      phase_q <= #(ORION_DLY_REG * 1ps) phase_d;
      data_q  <= #(ORION_DLY_REG * 1ps) data_d;
`else
      phase_q <= phase_d;
      data_q  <= data_d;
`endif
    end
  end

  assign req      = phase_q;
  assign data_out = data_q;

endmodule

// File: rtl/orion_reg_fork_n.sv
// N-way two-phase click fork with a per-token destination mask; one click per token, an all-zero mask drops the token.
// The fork waits only on selected outputs that still hold a token. ORION_FORK_SIM_DELAY_EN adds gate/click/register delays for zero-delay simulation.
module orion_reg_fork_n
  import orion_pkg::*;
#(
  parameter int                 NUM_OUT   = 2,
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   INIT      = '0,
  parameter logic               PA_INIT   = 1'b0,
  parameter logic [NUM_OUT-1:0] POUT_INIT = NUM_OUT'(orion_all_ones(NUM_OUT))
) (
  input  logic                     reset,
  input  logic                     inA_req,
  output logic                     inA_ack,
  input  logic [WIDTH-1:0]         inA_data,
  input  logic [NUM_OUT-1:0]       inA_mask,
  output logic [NUM_OUT-1:0]       out_req,
  input  logic [NUM_OUT-1:0]       out_ack,
  output logic [NUM_OUT*WIDTH-1:0] out_data
);

  logic               phase_a_q, phase_a_d;
  logic               token;
  logic               click;
  logic [NUM_OUT-1:0] ready;

  // Gating with reset keeps a pending token from clicking until reset releases.
`ifdef ORION_FORK_SIM_DELAY_EN
  assign #(ORION_DLY_GATE * 1ps)  token = inA_req ^ phase_a_q;
  assign #(ORION_DLY_CLICK * 1ps) click = token & (&ready) & ~reset;
`else
  assign token = inA_req ^ phase_a_q;
  assign click = token & (&ready) & ~reset;
`endif

  assign phase_a_d = ~phase_a_q;

  always_ff @(posedge click or posedge reset) begin
    if (reset) begin
      phase_a_q <= PA_INIT;
    end else begin
`ifdef ORION_FORK_SIM_DELAY_EN
      phase_a_q <= #(ORION_DLY_REG * 1ps) phase_a_d;
`else
      phase_a_q <= phase_a_d;
`endif
    end
  end

  assign inA_ack = phase_a_q;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slice
    orion_fork_slice #(
      .WIDTH (WIDTH),
      .INIT  (INIT),
      .P_INIT(POUT_INIT[i])
    ) u_slice (
      .reset   (reset),
      .click   (click),
      .sel     (inA_mask[i]),
      .out_ack (out_ack[i]),
      .data_in (inA_data),
      .req     (out_req[i]),
      .data_out(out_data[i*WIDTH +: WIDTH]),
      .ready   (ready[i])
    );
  end

endmodule

// File: doc/orion_reg_fork_n.md
Name: orion_reg_fork_n

Overview:
- N-way, two-phase (transition-signalling) click-based register fork with a per-token destination mask.
- Generalises the fixed 2-output fork:
  - output count is parameterised;
  - each token carries a mask selecting which outputs receive it;
  - each output has its own data register, so unselected outputs stay undisturbed.
- Sits between click pipeline stages wherever one producer feeds several consumers conditionally: broadcast, multicast or drop.

Parameters:
- NUM_OUT, 2, number of output channels (>=1).
- WIDTH, 1, data width per channel.
- INIT, 0, reset value of every output data register.
- PA_INIT, 0, reset value of input ack phase.
- POUT_INIT, all ones, NUM_OUT-bit reset phase vector for output reqs. Bit=1 means the output holds an initial token carrying INIT.

Ports:
- No clock; the block is self-timed.
- reset  in  1  asynchronous, active-high.
- inA_req  in  1  input request phase.
- inA_ack  out  1  input acknowledge phase.
- inA_data  in  WIDTH  bundled data; stable while inA_req differs from inA_ack.
- inA_mask  in  NUM_OUT  bundled destination mask; bit i=1 routes the token to output i. Same stability rule as inA_data.
- out_req  out  NUM_OUT  per-output request phase.
- out_ack  in  NUM_OUT  per-output acknowledge phase.
- out_data  out  NUM_OUT*WIDTH  per-output data; slice i is [i*WIDTH +: WIDTH].

Behaviour:
- Reset (async, immediate):
  - inA_ack=PA_INIT
  - out_req=POUT_INIT
  - every out_data slice=INIT
- State:
  - phase_a (1 bit)
  - phase_o[NUM_OUT-1:0]
  - data_reg[i] for each output
- Signals:
  - token = inA_req ^ phase_a
  - bubble[i] = ~(phase_o[i] ^ out_ack[i])
  - ready[i] = bubble[i] | ~inA_mask[i]
  - click = token & AND(ready[all i])
- Unselected outputs never block the fork, even if their token is still pending.
- On posedge click:
  - phase_a toggles.
  - For each i with inA_mask[i]=1: phase_o[i] toggles and data_reg[i] <= inA_data.
  - For each i with inA_mask[i]=0: phase_o[i] and data_reg[i] hold.
- inA_mask all zero: the token is consumed (inA_ack toggles) and all outputs hold. This is the drop/sink mode.
- inA_mask all ones: exact broadcast; equivalent to the classic fork when NUM_OUT=2.
- Data is registered before the req phase changes. The out_data slice is valid whenever out_req[i] != out_ack[i].
- Latency: one click per token. The next token can fire only after click deasserts, i.e. after token drops once phase_a has toggled.
- Outputs that are mid-handshake and unselected keep a frozen req and data.
- Reset mid-handshake:
  - State returns to reset values regardless of pending tokens.
  - The environment must also return its phases to the matching initial values.
  - Clicks are ignored while reset=1.
- Environment contract (checked in the bench, not enforced in RTL): inA_req, out_ack and mask changes must not glitch.

Optional Feature:
- Macro: ORION_FORK_SIM_DELAY_EN.
- Defined:
  - #10ps on the token/bubble derivations.
  - #15ps on click.
  - #10ps on the phase/data non-blocking updates.
  - Models click-pulse width for zero-delay simulation.
- Undefined: no delays; purely synthesisable, same function.

Decomposition:
- Shared package/header orion_pkg:
  - sim delay constants (ORION_DLY_GATE=10ps, ORION_DLY_CLICK=15ps, ORION_DLY_REG=10ps);
  - helper function for the all-ones default vector.
- One sub-module, orion_fork_slice:
  - one output's phase_o and data_reg, the bubble term and the ready term;
  - instantiated NUM_OUT times via generate;
  - the top holds phase_a and the click AND-reduction.

Test Plan:
- Reset, NUM_OUT=3, WIDTH=8, INIT=8'h5A, POUT_INIT=3'b111 -> inA_ack=0, out_req=3'b111, all out_data=8'h5A. Then toggle out_ack to 3'b111 -> no click.
- Broadcast: toggle inA_req with data=8'hC3, mask=3'b111 -> inA_ack toggles once; all out_req toggle; all slices=8'hC3.
- Multicast: mask=3'b010, data=8'h11 -> only out_req[1] toggles; out_data[1]=8'h11; slices 0 and 2 unchanged.
- Unselected blocked output: leave output 0's token unacked, send mask=3'b110, data=8'h22 -> click fires; output 0 keeps its old data. Then send mask=3'b001 -> stalls until out_ack[0] toggles, then completes.
- Drop: mask=3'b000 -> inA_ack toggles; out_req and out_data unchanged.
- Reset mid-transfer: assert reset with 2 tokens outstanding -> all state returns to reset values within 0 cycles; the next handshake after release behaves as in scenario 2.
